// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU issue controller:
//   - FPU_OP_*   three-bit opcodes of decoded XMM instructions
//   - FPU_SRC_*  two-bit select codes driven to both FPU operand muxes
//   - fpu_cmd_t  command record {op, xd, xs1, xs2, rs} at the default
//                XMM register address width
//   - fpu_dec_t / fpu_decode()  opcode -> {mul, src_a, src_b, reserved}
// ----------------------------------------------------------------------------
package fpu_pkg;

   localparam int FPU_XREG_AW = 3;

   // Opcodes; 6 and 7 are reserved and get dropped at the FIFO head
   localparam logic [2:0] FPU_OP_ADD = 3'd0;
   localparam logic [2:0] FPU_OP_SUB = 3'd1;
   localparam logic [2:0] FPU_OP_MUL = 3'd2;
   localparam logic [2:0] FPU_OP_MOV = 3'd3;
   localparam logic [2:0] FPU_OP_NEG = 3'd4;
   localparam logic [2:0] FPU_OP_LDG = 3'd5;

   // Operand mux select codes; bit 1 set means the XMM file is read
   localparam logic [1:0] FPU_SRC_GPR  = 2'b00;
   localparam logic [1:0] FPU_SRC_ONE  = 2'b01;
   localparam logic [1:0] FPU_SRC_XMM  = 2'b10;
   localparam logic [1:0] FPU_SRC_NXMM = 2'b11;

   typedef struct packed {
      logic [2:0]             op;
      logic [FPU_XREG_AW-1:0] xd;
      logic [FPU_XREG_AW-1:0] xs1;
      logic [FPU_XREG_AW-1:0] xs2;
      logic [4:0]             rs;
   } fpu_cmd_t;

   typedef struct packed {
      logic       mul;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       rsvd;
   } fpu_dec_t;

   // MOV and NEG are built as multiply-by-one, LDG as GPR times one
   function automatic fpu_dec_t fpu_decode(input logic [2:0] op);
      fpu_dec_t d;
      d.mul   = 1'b0;
      d.src_a = FPU_SRC_XMM;
      d.src_b = FPU_SRC_XMM;
      d.rsvd  = 1'b0;
      case (op)
         FPU_OP_ADD: ;
         FPU_OP_SUB: d.src_b = FPU_SRC_NXMM;
         FPU_OP_MUL: d.mul = 1'b1;
         FPU_OP_MOV: begin
            d.mul   = 1'b1;
            d.src_b = FPU_SRC_ONE;
         end
         FPU_OP_NEG: begin
            d.mul   = 1'b1;
            d.src_a = FPU_SRC_NXMM;
            d.src_b = FPU_SRC_ONE;
         end
         FPU_OP_LDG: begin
            d.mul   = 1'b1;
            d.src_a = FPU_SRC_GPR;
            d.src_b = FPU_SRC_ONE;
         end
         default: d.rsvd = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// fpu_cmd_fifo
// Circular command buffer in front of the issue logic. DEPTH must be a
// power of two so the read/write pointers wrap naturally.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_push, i_din      write request and data (ignored while full)
//   i_pop              read request (ignored while empty)
//   o_dout             head entry
//   o_full, o_empty    occupancy flags from the registered count
//   o_count            number of stored entries
// ----------------------------------------------------------------------------
module fpu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Pointer and occupancy bookkeeping; a simultaneous push and pop
   // moves both pointers and leaves the count alone
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   // Storage needs no reset; only entries below the count are ever read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// fpu_issue_ctrl
// In-order scheduler between decoded XMM instructions and a fixed-latency
// FPU. Commands are buffered in fpu_cmd_fifo; the head issues only when a
// per-register scoreboard shows no RAW/WAW hazard. Issue outputs are
// registered, and a FPU_LAT-deep {valid,addr} pipe produces the writeback.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (ready = FIFO not full)
//   cmd_op, cmd_xd, cmd_xs1, cmd_xs2, cmd_rs   command fields
//   cmd_err                           one-cycle pulse: reserved opcode dropped
//   fpu_issue, fpu_mul, src_a, src_b  FPU operand strobe, operation, mux selects
//   xs_a_addr, xs_b_addr, rs_addr     register file read addresses
//   wb_valid, wb_addr                 result writeback strobe and XMM reg
//   busy                              queued, issuing or in-flight work
// Optional feature macro FPU_STATS_EN adds stat_issued and stat_stall
// (wrapping 32-bit counters of issues and of hazard-blocked cycles).
// ----------------------------------------------------------------------------
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int FPU_LAT   = 4,
   parameter int XREG_AW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [XREG_AW-1:0] cmd_xd,
   input  logic [XREG_AW-1:0] cmd_xs1,
   input  logic [XREG_AW-1:0] cmd_xs2,
   input  logic [4:0]         cmd_rs,
   output logic               cmd_err,
   output logic               fpu_issue,
   output logic               fpu_mul,
   output logic [1:0]         src_a,
   output logic [1:0]         src_b,
   output logic [XREG_AW-1:0] xs_a_addr,
   output logic [XREG_AW-1:0] xs_b_addr,
   output logic [4:0]         rs_addr,
   output logic               wb_valid,
   output logic [XREG_AW-1:0] wb_addr,
   output logic               busy
`ifdef FPU_STATS_EN
   ,
   output logic [31:0]        stat_issued,
   output logic [31:0]        stat_stall
`endif
);

   localparam int NREG  = 1 << XREG_AW;
   localparam int CMD_W = 8 + 3 * XREG_AW;
   localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

   // FIFO interface
   logic [CMD_W-1:0]   w_push_data;
   logic [CMD_W-1:0]   w_head;
   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic               w_push;
   logic               w_pop;

   // Head fields and decode
   logic [2:0]         w_head_op;
   logic [XREG_AW-1:0] w_head_xd;
   logic [XREG_AW-1:0] w_head_xs1;
   logic [XREG_AW-1:0] w_head_xs2;
   logic [4:0]         w_head_rs;
   fpu_dec_t           w_dec;

   // Hazard evaluation
   logic               w_xd_free;
   logic               w_xs1_free;
   logic               w_xs2_free;
   logic               w_head_ok;
   logic               w_pop_issue;
   logic               w_pop_drop;
   logic               w_stall;

   // State
   logic [NREG-1:0]    r_sb;
   logic               r_fpu_issue;
   logic               r_fpu_mul;
   logic [1:0]         r_src_a;
   logic [1:0]         r_src_b;
   logic [XREG_AW-1:0] r_xs_a;
   logic [XREG_AW-1:0] r_xs_b;
   logic [4:0]         r_rs;
   logic [XREG_AW-1:0] r_xd;
   logic               r_cmd_err;
   logic [FPU_LAT-1:0] r_pipe_v;
   logic [XREG_AW-1:0] r_pipe_a [FPU_LAT];

   assign w_push_data = {cmd_op, cmd_xd, cmd_xs1, cmd_xs2, cmd_rs};
   assign w_push      = cmd_valid && !w_full;
   assign cmd_ready   = !w_full;

   fpu_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_push_data),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_head_op  = w_head[CMD_W-1 -: 3];
   assign w_head_xd  = w_head[5+3*XREG_AW-1 -: XREG_AW];
   assign w_head_xs1 = w_head[5+2*XREG_AW-1 -: XREG_AW];
   assign w_head_xs2 = w_head[5+XREG_AW-1 -: XREG_AW];
   assign w_head_rs  = w_head[4:0];
   assign w_dec      = fpu_decode(w_head_op);

   // A register is free when its scoreboard bit is clear or when its result
   // is being written back this very cycle. An operand only matters when
   // its mux actually reads the XMM file (select bit 1), so LDG ignores
   // xs1 and the multiply-by-one ops ignore xs2, while SUB still reads xs2.
   always_comb begin
      w_xd_free   = !r_sb[w_head_xd]  || (wb_valid && (wb_addr == w_head_xd));
      w_xs1_free  = !r_sb[w_head_xs1] || (wb_valid && (wb_addr == w_head_xs1));
      w_xs2_free  = !r_sb[w_head_xs2] || (wb_valid && (wb_addr == w_head_xs2));
      w_head_ok   = w_xd_free
                    && (!w_dec.src_a[1] || w_xs1_free)
                    && (!w_dec.src_b[1] || w_xs2_free);
      w_pop_issue = !w_empty && !w_dec.rsvd && w_head_ok;
      w_pop_drop  = !w_empty && w_dec.rsvd;
      w_stall     = !w_empty && !w_dec.rsvd && !w_head_ok;
   end

   assign w_pop = w_pop_issue || w_pop_drop;

   // Issue register stage. Selects and addresses only load on a real issue,
   // so they stay stable between issues; a reserved op pops without
   // touching them and just raises cmd_err for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fpu_issue <= 1'b0;
         r_fpu_mul   <= 1'b0;
         r_src_a     <= '0;
         r_src_b     <= '0;
         r_xs_a      <= '0;
         r_xs_b      <= '0;
         r_rs        <= '0;
         r_xd        <= '0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_fpu_issue <= w_pop_issue;
         r_cmd_err   <= w_pop_drop;
         if (w_pop_issue) begin
            r_fpu_mul <= w_dec.mul;
            r_src_a   <= w_dec.src_a;
            r_src_b   <= w_dec.src_b;
            r_xs_a    <= w_head_xs1;
            r_xs_b    <= w_head_xs2;
            r_rs      <= w_head_rs;
            r_xd      <= w_head_xd;
         end
      end
   end

   // Scoreboard: clear on writeback, then set on issue. The set is written
   // last so it wins when both hit the same register in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sb <= '0;
      end else begin
         if (wb_valid)    r_sb[wb_addr]   <= 1'b0;
         if (w_pop_issue) r_sb[w_head_xd] <= 1'b1;
      end
   end

   // Latency pipe fed by the registered issue strobe, so the last stage
   // fires exactly FPU_LAT cycles after fpu_issue. Reset drops everything
   // in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe_v <= '0;
         for (int i = 0; i < FPU_LAT; i++) r_pipe_a[i] <= '0;
      end else begin
         r_pipe_v[0] <= r_fpu_issue;
         r_pipe_a[0] <= r_xd;
         for (int i = 1; i < FPU_LAT; i++) begin
            r_pipe_v[i] <= r_pipe_v[i-1];
            r_pipe_a[i] <= r_pipe_a[i-1];
         end
      end
   end

   assign fpu_issue = r_fpu_issue;
   assign fpu_mul   = r_fpu_mul;
   assign src_a     = r_src_a;
   assign src_b     = r_src_b;
   assign xs_a_addr = r_xs_a;
   assign xs_b_addr = r_xs_b;
   assign rs_addr   = r_rs;
   assign cmd_err   = r_cmd_err;
   assign wb_valid  = r_pipe_v[FPU_LAT-1];
   assign wb_addr   = r_pipe_a[FPU_LAT-1];
   assign busy      = (w_count != '0) || r_fpu_issue || (|r_pipe_v);

`ifdef FPU_STATS_EN
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_stall;

   // Activity counters; both wrap naturally at 2**32
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_issued <= '0;
         r_stat_stall  <= '0;
      end else begin
         if (r_fpu_issue) r_stat_issued <= r_stat_issued + 32'd1;
         if (w_stall)     r_stat_stall  <= r_stat_stall + 32'd1;
      end
   end

   assign stat_issued = r_stat_issued;
   assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Directed bench for fpu_issue_ctrl (CMD_DEPTH=4, FPU_LAT=4). Each test
// pushes its hand-computed issue / writeback / error expectations into
// queues; a negedge monitor pops and compares them whenever the DUT
// raises fpu_issue, wb_valid or cmd_err. Honours FPU_STATS_EN.
// ----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_xd;
   logic [2:0] cmd_xs1;
   logic [2:0] cmd_xs2;
   logic [4:0] cmd_rs;
   logic       cmd_err;
   logic       fpu_issue;
   logic       fpu_mul;
   logic [1:0] src_a;
   logic [1:0] src_b;
   logic [2:0] xs_a_addr;
   logic [2:0] xs_b_addr;
   logic [4:0] rs_addr;
   logic       wb_valid;
   logic [2:0] wb_addr;
   logic       busy;
`ifdef FPU_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_stall;
`endif

   fpu_issue_ctrl #(
      .CMD_DEPTH (4),
      .FPU_LAT   (4),
      .XREG_AW   (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_xd    (cmd_xd),
      .cmd_xs1   (cmd_xs1),
      .cmd_xs2   (cmd_xs2),
      .cmd_rs    (cmd_rs),
      .cmd_err   (cmd_err),
      .fpu_issue (fpu_issue),
      .fpu_mul   (fpu_mul),
      .src_a     (src_a),
      .src_b     (src_b),
      .xs_a_addr (xs_a_addr),
      .xs_b_addr (xs_b_addr),
      .rs_addr   (rs_addr),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .busy      (busy)
`ifdef FPU_STATS_EN
      ,
      .stat_issued (stat_issued),
      .stat_stall  (stat_stall)
`endif
   );

   typedef struct packed {
      int         cyc;
      logic       mul;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] xa;
      logic [2:0] xb;
      logic [4:0] rs;
   } issueExp_t;

   typedef struct packed {
      int         cyc;
      logic [2:0] addr;
   } wbExp_t;

   issueExp_t issueQ[$];
   wbExp_t    wbQ[$];
   int        errQ[$];

   issueExp_t issueAct;
   issueExp_t issueExp;
   wbExp_t    wbAct;
   wbExp_t    wbExp;
   int        errExp;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   bit sawFull = 0;
   int t0;

   // Free-running clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Records that the producer was held off by a full FIFO
   always @(negedge clk) begin
      if (!reset && cmd_valid && !cmd_ready) sawFull = 1;
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Scoreboard monitor: compare every DUT event against the queue heads
   always @(negedge clk) begin
      if (!reset) begin
         if (fpu_issue) begin
            issueAct = '{cyc: cyc, mul: fpu_mul, sa: src_a, sb: src_b,
                         xa: xs_a_addr, xb: xs_b_addr, rs: rs_addr};
            checks++;
            if (issueQ.size() == 0) begin
               $display("[TB] FAIL issue_unexpected act=%p exp=none", issueAct);
            end else begin
               issueExp = issueQ.pop_front();
               if (issueAct === issueExp) passes++;
               else $display("[TB] FAIL issue act=%p exp=%p", issueAct, issueExp);
            end
         end
         if (wb_valid) begin
            wbAct = '{cyc: cyc, addr: wb_addr};
            checks++;
            if (wbQ.size() == 0) begin
               $display("[TB] FAIL wb_unexpected act=%p exp=none", wbAct);
            end else begin
               wbExp = wbQ.pop_front();
               if (wbAct === wbExp) passes++;
               else $display("[TB] FAIL wb act=%p exp=%p", wbAct, wbExp);
            end
         end
         if (cmd_err) begin
            checks++;
            if (errQ.size() == 0) begin
               $display("[TB] FAIL err_unexpected act_cyc=%0d exp=none", cyc);
            end else begin
               errExp = errQ.pop_front();
               if (cyc == errExp) passes++;
               else $display("[TB] FAIL err act_cyc=%0d exp_cyc=%0d", cyc, errExp);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s act=%0h exp=%0h", name, act, exp);
   endtask

   // Offers one command, holds it until accepted, then drops cmd_valid.
   // Entered and left just after a rising edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] xd,
                                input logic [2:0] xs1, input logic [2:0] xs2,
                                input logic [4:0] rs);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_xd    = xd;
      cmd_xs1   = xs1;
      cmd_xs2   = xs2;
      cmd_rs    = rs;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         checks++;
         $display("[TB] FAIL accept_timeout act=ready0 exp=ready1");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Returns at the falling edge inside cycle c
   task automatic waitCycle(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   // Waits for the DUT to drain and all expectations to be consumed
   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while ((busy || issueQ.size() != 0 || wbQ.size() != 0 || errQ.size() != 0) && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         checks++;
         $display("[TB] FAIL idle_timeout act=busy%0d exp=idle", busy);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic issueExp_t mkIssue(int c, logic m, logic [1:0] a, logic [1:0] b,
                                         logic [2:0] xa, logic [2:0] xb, logic [4:0] rs);
      issueExp_t e;
      e = '{cyc: c, mul: m, sa: a, sb: b, xa: xa, xb: xb, rs: rs};
      return e;
   endfunction

   function automatic wbExp_t mkWb(int c, logic [2:0] a);
      wbExp_t e;
      e = '{cyc: c, addr: a};
      return e;
   endfunction

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = FPU_OP_ADD;
      cmd_xd    = 3'd1;
      cmd_xs1   = 3'd2;
      cmd_xs2   = 3'd3;
      cmd_rs    = 5'd0;

      // Test 1: reset held with cmd_valid high; everything stays quiet
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t1_reset_outs",
                     {fpu_issue, fpu_mul, src_a, src_b, xs_a_addr, xs_b_addr,
                      rs_addr, wb_valid, wb_addr, busy, cmd_err}, 64'd0);
      end
      @(posedge clk);
      #1;
      reset     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("t1_ready_after", cmd_ready, 1);
      checkOutput("t1_busy_after", busy, 0);
      @(negedge clk);
      checkOutput("t1_nothing_queued", busy, 0);
      @(posedge clk);
      #1;

      // Test 2: single ADD x1 = x2 + x3
      resetDut();
      t0 = cyc;
      issueQ.push_back(mkIssue(t0 + 2, 1'b0, 2'b10, 2'b10, 3'd2, 3'd3, 5'd0));
      wbQ.push_back(mkWb(t0 + 6, 3'd1));
      applyStimulus(FPU_OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
      waitCycle(t0 + 6);
      checkOutput("t2_busy_at_wb", busy, 1);
      waitCycle(t0 + 7);
      checkOutput("t2_busy_idle", busy, 0);
      waitIdle();

      // Test 3: RAW, MUL x4 = x1 * x1 waits for x1 writeback (bypassed)
      resetDut();
      t0 = cyc;
      issueQ.push_back(mkIssue(t0 + 2, 1'b0, 2'b10, 2'b10, 3'd2, 3'd3, 5'd0));
      wbQ.push_back(mkWb(t0 + 6, 3'd1));
      applyStimulus(FPU_OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
      issueQ.push_back(mkIssue(t0 + 7, 1'b1, 2'b10, 2'b10, 3'd1, 3'd1, 5'd0));
      wbQ.push_back(mkWb(t0 + 11, 3'd4));
      applyStimulus(FPU_OP_MUL, 3'd4, 3'd1, 3'd1, 5'd0);
      waitIdle();
`ifdef FPU_STATS_EN
      checkOutput("t3_stat_stall", stat_stall, 4);
      checkOutput("t3_stat_issued", stat_issued, 2);
`endif

      // Test 4: LDG x5 = r7, then NEG x6 = -x5
      resetDut();
      t0 = cyc;
      issueQ.push_back(mkIssue(t0 + 2, 1'b1, 2'b00, 2'b01, 3'd0, 3'd0, 5'd7));
      wbQ.push_back(mkWb(t0 + 6, 3'd5));
      applyStimulus(FPU_OP_LDG, 3'd5, 3'd0, 3'd0, 5'd7);
      issueQ.push_back(mkIssue(t0 + 7, 1'b1, 2'b11, 2'b01, 3'd5, 3'd0, 5'd0));
      wbQ.push_back(mkWb(t0 + 11, 3'd6));
      applyStimulus(FPU_OP_NEG, 3'd6, 3'd5, 3'd0, 5'd0);
      waitIdle();

      // Test 5: six chained ADD x1 = x1 + x1; the FIFO fills and backs up
      resetDut();
      t0 = cyc;
      sawFull = 0;
      for (int k = 0; k < 6; k++) begin
         issueQ.push_back(mkIssue(t0 + 2 + 5 * k, 1'b0, 2'b10, 2'b10, 3'd1, 3'd1, 5'd0));
         wbQ.push_back(mkWb(t0 + 6 + 5 * k, 3'd1));
         applyStimulus(FPU_OP_ADD, 3'd1, 3'd1, 3'd1, 5'd0);
      end
      checkOutput("t5_ready_dropped", sawFull, 1);
      waitIdle();

      // Test 6a: reserved op 7 between two independent ADDs
      resetDut();
      t0 = cyc;
      issueQ.push_back(mkIssue(t0 + 2, 1'b0, 2'b10, 2'b10, 3'd2, 3'd3, 5'd0));
      wbQ.push_back(mkWb(t0 + 6, 3'd1));
      applyStimulus(FPU_OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
      errQ.push_back(t0 + 3);
      applyStimulus(3'd7, 3'd7, 3'd7, 3'd7, 5'd31);
      issueQ.push_back(mkIssue(t0 + 4, 1'b0, 2'b10, 2'b10, 3'd5, 3'd6, 5'd0));
      wbQ.push_back(mkWb(t0 + 8, 3'd4));
      applyStimulus(FPU_OP_ADD, 3'd4, 3'd5, 3'd6, 5'd0);
      waitIdle();

      // Test 6b: reset while an ADD is in the latency pipe; no writeback
      resetDut();
      t0 = cyc;
      issueQ.push_back(mkIssue(t0 + 2, 1'b0, 2'b10, 2'b10, 3'd2, 3'd3, 5'd0));
      applyStimulus(FPU_OP_ADD, 3'd1, 3'd2, 3'd3, 5'd0);
      waitCycle(t0 + 3);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      waitCycle(t0 + 12);
      checkOutput("t6_busy_after_reset", busy, 0);
      checkOutput("t6_ready_after_reset", cmd_ready, 1);

      // Every queued expectation must have been matched
      checkOutput("end_issueQ_empty", issueQ.size(), 0);
      checkOutput("end_wbQ_empty", wbQ.size(), 0);
      checkOutput("end_errQ_empty", errQ.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
